udp_tx_arbiter: RTL and testbench
=================================

UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of packet requesters (2..8).
REQ-002 Parameter MAX_LEN, default 16'd1472, largest legal UDP payload length in bytes.
REQ-003 Parameter IPG_CYCLES, default 64, idle clk_200m cycles enforced between packets.
REQ-004 Parameter TIMEOUT_CYCLES, default 20'd1000000, WAIT_DONE watchdog limit.
REQ-005 Reset rstn, synchronous, active-low; clock clk_200m.
REQ-006 clk_200m  in  1  block clock.
REQ-007 rstn  in  1  synchronous active-low reset.
REQ-008 req  in  NUM_REQ  level request per requester, held until ack or reject.
REQ-009 req_len  in  16*NUM_REQ  payload length per requester, slice i = [16*i+15:16*i], stable while req[i]=1.
REQ-010 grant  out  NUM_REQ  one-hot owner of the UDP send FIFO mux.
REQ-011 ack  out  NUM_REQ  one-cycle pulse: packet of requester i completed.
REQ-012 reject  out  NUM_REQ  one-cycle pulse: request i dropped for illegal length.
REQ-013 send_en  out  1  one-cycle start pulse to the UDP engine.
REQ-014 send_len  out  16  latched length for the current packet.
REQ-015 send_done  in  1  one-cycle pulse from the UDP engine, already synchronized into clk_200m.
REQ-016 timeout_err  out  1  one-cycle pulse on watchdog expiry.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, START, WAIT_DONE, GAP; one state per cycle minimum.
REQ-019 IDLE: when any req is high, select the first requester at or after rr_ptr+1 (mod NUM_REQ) with req high.
REQ-020 Selected length 0 or greater than MAX_LEN: pulse reject[i] for one cycle, set rr_ptr=i, remain in IDLE; no grant, no send_en.
REQ-021 Selected legal length: latch send_len, set grant[i], set rr_ptr=i, go to START in the next cycle.
REQ-022 START: send_en=1 for exactly one cycle, then WAIT_DONE; grant held unchanged from START through WAIT_DONE.
REQ-023 WAIT_DONE: on send_done, pulse ack[i] for one cycle, clear grant, go to GAP.
REQ-024 send_done in any state other than WAIT_DONE is ignored.
REQ-025 GAP: count IPG_CYCLES cycles, then go to IDLE; new requests are not sampled during GAP.
REQ-026 Latency from req rising in idle block to send_en: 2 cycles.
REQ-027 Requests deasserted before selection are not served; deassertion after grant does not abort the packet.
REQ-028 Round-robin is starvation-free: with all requests high, each requester is served once per NUM_REQ packets.
REQ-029 Counters saturate; no wrap-around observable at outputs.

Reset
REQ-030 On rstn=0 at a clk_200m edge: state=IDLE, rr_ptr=NUM_REQ-1, grant=0, ack=0, reject=0, send_en=0, send_len=0, timeout_err=0, busy=0, all counters 0.
REQ-031 Reset mid-packet abandons the packet without ack; the UDP engine sees no further send_en until re-arbitration.

Configuration
REQ-032 Macro UDP_ARB_TIMEOUT_EN defined: WAIT_DONE counts cycles; on reaching TIMEOUT_CYCLES without send_done, pulse timeout_err, clear grant without ack, go to GAP.
REQ-033 Macro UDP_ARB_TIMEOUT_EN undefined: no watchdog counter; WAIT_DONE waits indefinitely; timeout_err tied 0.

Structure
REQ-034 Shared package udp_arb_pkg holds the FSM state encoding and the default MAX_LEN, IPG_CYCLES, and TIMEOUT_CYCLES constants.
REQ-035 One sub-module rr_arbiter, combinational round-robin pick from req and rr_ptr, returning index and valid.

Verification
REQ-036 req=4'b0001, len0=100 -> send_en at cycle 2, send_len=100, grant=0001; send_done -> ack[0] next cycle, busy low after 64+1 cycles.
REQ-037 req=4'b1111, all len=64, send_done 10 cycles after each send_en -> grants in order 0001,0010,0100,1000,0001.
REQ-038 req[2]=1, len2=0, then len2=1473 -> reject[2] pulse each time; no send_en or grant.
REQ-039 UDP_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100, no send_done -> timeout_err at cycle 100 of WAIT_DONE, no ack, block returns to IDLE after GAP.
REQ-040 rstn low during WAIT_DONE -> all outputs 0 next cycle; a later send_done produces no ack.

Source files
------------

// File: rtl/udp_arb_pkg.sv
// Shared definitions for the UDP transmit arbiter: FSM state encoding,
// default sizing constants and the payload-length legality rule.
package udp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } arb_state_t;

    localparam logic [15:0] DEF_MAX_LEN        = 16'd1472;
    localparam int          DEF_IPG_CYCLES     = 64;
    localparam logic [19:0] DEF_TIMEOUT_CYCLES = 20'd1000000;

    // One counter serves both the inter-packet gap and the watchdog
    localparam int CNT_W = 20;

    // A zero-length or oversize payload is never handed to the UDP engine
    function automatic logic len_legal(input logic [15:0] len, input logic [15:0] max_len);
        return (len != 16'd0) && (len <= max_len);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: returns the first requester strictly after
// i_ptr (wrapping modulo NUM_REQ) whose request is high.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    // Pick the active requester with the smallest forward distance from i_ptr+1
    always_comb begin
        int w_dist;
        int w_best;
        o_idx   = '0;
        o_valid = 1'b0;
        w_best  = NUM_REQ;
        w_dist  = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (j - int'(i_ptr) - 1 + 2 * NUM_REQ) % NUM_REQ;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_idx   = IDX_W'(j);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Round-robin arbiter granting requesters ownership of the UDP send FIFO mux.
// One packet at a time: IDLE -> START (send_en) -> WAIT_DONE -> GAP -> IDLE.
// Illegal lengths are rejected in IDLE without touching the UDP engine.
// Optional feature: define UDP_ARB_TIMEOUT_EN to enable the WAIT_DONE watchdog;
// without it WAIT_DONE waits indefinitely and timeout_err is tied low.
module udp_tx_arbiter
    import udp_arb_pkg::*;
#(
    parameter int          NUM_REQ        = 4,
    parameter logic [15:0] MAX_LEN        = DEF_MAX_LEN,
    parameter int          IPG_CYCLES     = DEF_IPG_CYCLES,
    parameter logic [19:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk_200m,
    input  logic                  rstn,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] req_len,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    ack,
    output logic [NUM_REQ-1:0]    reject,
    output logic                  send_en,
    output logic [15:0]           send_len,
    input  logic                  send_done,
    output logic                  timeout_err,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Elaboration-time sanity checks on the configuration
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("udp_tx_arbiter: NUM_REQ must be 2..8");
    end
    if (IPG_CYCLES < 1 || TIMEOUT_CYCLES == 20'd0) begin : g_bad_counts
        $error("udp_tx_arbiter: IPG_CYCLES and TIMEOUT_CYCLES must be nonzero");
    end

    arb_state_t           r_state;
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_ack;
    logic [NUM_REQ-1:0]   r_reject;
    logic                 r_send_en;
    logic [15:0]          r_send_len;
    logic [CNT_W-1:0]     r_cnt;

    logic [IDX_W-1:0]     w_idx;
    logic                 w_valid;
    logic [15:0]          w_sel_len;
    logic [NUM_REQ-1:0]   w_sel_oh;
    logic [CNT_W-1:0]     w_cnt_inc;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req   (req),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    // Length and one-hot grant vector of the selected requester
    always_comb begin
        w_sel_len = 16'd0;
        w_sel_oh  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_sel_len   = req_len[16*i +: 16];
                w_sel_oh[i] = 1'b1;
            end
        end
    end

    // Saturating increment so the counter can never wrap
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

`ifdef UDP_ARB_TIMEOUT_EN
    logic r_timeout_err;
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

    // Arbitration FSM with registered grant/ack/reject/send outputs
    always_ff @(posedge clk_200m) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= IDX_W'(NUM_REQ - 1);
            r_grant       <= '0;
            r_ack         <= '0;
            r_reject      <= '0;
            r_send_en     <= 1'b0;
            r_send_len    <= 16'd0;
            r_cnt         <= '0;
`ifdef UDP_ARB_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_ack         <= '0;
            r_reject      <= '0;
            r_send_en     <= 1'b0;
`ifdef UDP_ARB_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_rr_ptr <= w_idx;
                        if (len_legal(w_sel_len, MAX_LEN)) begin
                            r_grant    <= w_sel_oh;
                            r_send_len <= w_sel_len;
                            r_state    <= ST_START;
                        end else begin
                            r_reject   <= w_sel_oh;
                        end
                    end
                end
                ST_START: begin
                    r_send_en <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (send_done) begin
                        r_ack   <= r_grant;
                        r_grant <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_GAP;
`ifdef UDP_ARB_TIMEOUT_EN
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 20'd1)) begin
                        r_timeout_err <= 1'b1;
                        r_grant       <= '0;
                        r_cnt         <= '0;
                        r_state       <= ST_GAP;
                    end else begin
                        r_cnt <= w_cnt_inc;
`endif
                    end
                end
                ST_GAP: begin
                    if (r_cnt >= CNT_W'(IPG_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant    = r_grant;
    assign ack      = r_ack;
    assign reject   = r_reject;
    assign send_en  = r_send_en;
    assign send_len = r_send_len;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Randomized bench for udp_tx_arbiter. The reference model is transaction
// level: a table of pending requests, the last-served index, the length rule
// and the fixed protocol latencies.
module tb_udp_tx_arbiter;

    localparam int          N    = 4;
    localparam int          IPG  = 64;
    localparam int          TMO  = 100;
    localparam logic [15:0] MAXL = 16'd1472;

    logic              clk_200m = 1'b0;
    logic              rstn;
    logic [N-1:0]      req;
    logic [16*N-1:0]   req_len;
    logic [N-1:0]      grant, ack, reject;
    logic              send_en;
    logic [15:0]       send_len;
    logic              send_done;
    logic              timeout_err;
    logic              busy;

    udp_tx_arbiter #(
        .NUM_REQ        (N),
        .MAX_LEN        (MAXL),
        .IPG_CYCLES     (IPG),
        .TIMEOUT_CYCLES (20'(TMO))
    ) dut (
        .clk_200m    (clk_200m),
        .rstn        (rstn),
        .req         (req),
        .req_len     (req_len),
        .grant       (grant),
        .ack         (ack),
        .reject      (reject),
        .send_en     (send_en),
        .send_len    (send_len),
        .send_done   (send_done),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk_200m = ~clk_200m;

    int n_vec = 0;
    int n_err = 0;

    // Model state: what each requester is asking for and who was served last
    bit          pend [N];
    logic [15:0] plen [N];
    int          last;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_200m);
        #1;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req[i]              = pend[i];
            req_len[16*i +: 16] = plen[i];
        end
    endtask

    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            if (pend[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit legal(input logic [15:0] len);
        return (len >= 16'd1) && (len <= MAXL);
    endfunction

    function automatic logic [15:0] rand_len();
        case ($urandom_range(0, 7))
            0:       return 16'd0;
            1:       return 16'(MAXL + 16'd1);
            2:       return MAXL;
            3:       return 16'd1;
            4:       return 16'($urandom_range(1473, 65535));
            default: return 16'($urandom_range(1, 1472));
        endcase
    endfunction

    // One arbitration decision starting with the DUT idle; packets run to ack and gap end
    task automatic serve_round(input int dly, input bit drop_early, input bit stray_done, output int won);
        int          w;
        int          n;
        logic [15:0] l;
        logic [N-1:0] seen;
        drive_reqs();
        w   = pick();
        won = w;
        if (w < 0) return;
        l = plen[w];
        tick();
        last = w;
        if (!legal(l)) begin
            chk("reject", 32'(reject), 32'(1 << w));
            chk("rej_grant", 32'(grant), 0);
            chk("rej_send_en", 32'(send_en), 0);
            chk("rej_busy", 32'(busy), 0);
            pend[w] = 0;
            req[w]  = 1'b0;
        end else begin
            chk("grant", 32'(grant), 32'(1 << w));
            chk("grant_busy", 32'(busy), 1);
            chk("early_send_en", 32'(send_en), 0);
            if (drop_early) begin
                pend[w] = 0;
                req[w]  = 1'b0;
            end
            tick();
            chk("send_en", 32'(send_en), 1);
            chk("send_len", 32'(send_len), 32'(l));
            chk("grant_hold", 32'(grant), 32'(1 << w));
            tick();
            chk("send_en_pulse", 32'(send_en), 0);
            repeat (dly) tick();
            chk("wait_grant", 32'(grant), 32'(1 << w));
            chk("wait_no_ack", 32'(ack), 0);
            send_done = 1'b1;
            tick();
            send_done = 1'b0;
            chk("ack", 32'(ack), 32'(1 << w));
            chk("ack_grant_clr", 32'(grant), 0);
            chk("no_timeout", 32'(timeout_err), 0);
            pend[w] = 0;
            req[w]  = 1'b0;
            n    = 0;
            seen = '0;
            while (busy && n < 300) begin
                if (stray_done && n == 10) send_done = 1'b1;
                tick();
                send_done = 1'b0;
                seen = seen | ack | grant | reject;
                n++;
            end
            chk("gap_len", 32'(n), 32'(IPG));
            chk("gap_quiet", 32'(seen), 0);
        end
    endtask

    initial begin
        int won;
        int n;
        rstn      = 1'b0;
        req       = '0;
        req_len   = '0;
        send_done = 1'b0;
        last      = N - 1;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            plen[i] = 16'd0;
        end
        tick(); tick(); tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_reject", 32'(reject), 0);
        chk("rst_send_en", 32'(send_en), 0);
        chk("rst_send_len", 32'(send_len), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_busy", 32'(busy), 0);
        rstn = 1'b1;
        tick();

        // Single requester, length 100
        pend[0] = 1; plen[0] = 16'd100;
        serve_round(5, 0, 0, won);
        chk("single_winner", 32'(won), 0);

        // All four requesting: strict rotation starting after the last served
        for (int i = 0; i < N; i++) begin
            pend[i] = 1; plen[i] = 16'd64;
        end
        for (int k = 0; k < 5; k++) begin
            serve_round(10, 0, 0, won);
            chk("rr_order", 32'(won), 32'((k + 1) % N));
            pend[won] = 1;
        end
        for (int i = 0; i < N; i++) pend[i] = 0;
        drive_reqs();
        tick();

        // Illegal lengths on requester 2
        pend[2] = 1; plen[2] = 16'd0;
        serve_round(0, 0, 0, won);
        pend[2] = 1; plen[2] = 16'd1473;
        serve_round(0, 0, 0, won);
        tick();
        chk("after_rej_idle", 32'(busy), 0);

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1;
                    plen[i] = rand_len();
                end
            end
            if (pick() < 0) begin
                n = $urandom_range(0, N - 1);
                pend[n] = 1;
                plen[n] = rand_len();
            end
            serve_round($urandom_range(0, 20), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), won);
        end
        for (int i = 0; i < N; i++) pend[i] = 0;
        drive_reqs();
        tick();

`ifdef UDP_ARB_TIMEOUT_EN
        // Watchdog: no send_done ever arrives
        pend[1] = 1; plen[1] = 16'd10;
        drive_reqs();
        won = pick();
        tick();
        last = won;
        chk("tmo_grant", 32'(grant), 32'(1 << won));
        tick();
        chk("tmo_send_en", 32'(send_en), 1);
        pend[won] = 0;
        req[won]  = 1'b0;
        n = 0;
        while (!timeout_err && n < 300) begin
            tick();
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'(TMO));
        chk("tmo_no_ack", 32'(ack), 0);
        chk("tmo_grant_clr", 32'(grant), 0);
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        chk("tmo_gap_len", 32'(n), 32'(IPG));
`endif

        // Reset while waiting for send_done abandons the packet
        pend[3] = 1; plen[3] = 16'd200;
        drive_reqs();
        won = pick();
        tick();
        chk("mid_grant", 32'(grant), 32'(1 << won));
        tick();
        tick();
        rstn = 1'b0;
        tick();
        chk("mid_rst_grant", 32'(grant), 0);
        chk("mid_rst_ack", 32'(ack), 0);
        chk("mid_rst_send_en", 32'(send_en), 0);
        chk("mid_rst_send_len", 32'(send_len), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_timeout", 32'(timeout_err), 0);
        rstn = 1'b1;
        for (int i = 0; i < N; i++) pend[i] = 0;
        last = N - 1;
        drive_reqs();
        tick();
        send_done = 1'b1;
        tick();
        send_done = 1'b0;
        chk("late_done_ack", 32'(ack), 0);
        tick();
        chk("late_done_busy", 32'(busy), 0);

        // Re-arbitration after reset starts from requester 0
        pend[0] = 1; plen[0] = 16'd33;
        pend[2] = 1; plen[2] = 16'd44;
        serve_round(3, 0, 0, won);
        chk("post_rst_winner", 32'(won), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
